mf_serial_driver: RTL and testbench

MF_SERIAL_DRIVER -- requirements
Module: mf_serial_driver

---
 rtl/mf_serial_driver.sv | 106 ++++++++++
 tb/tb_mf_serial_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mf_serial_driver.sv
// Bit-serial driver for a multifunction gate: one operand bit per cycle, result valid WIDTH cycles after accept.
// in_ready low while busy; result held in DONE until out_ready, then retained until the next accept.
module mf_serial_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [1:0]       in_mode,
  output logic             gate_x,
  output logic             gate_y,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [KW-1:0]    k_next;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [1:0]       mode_r;
  logic             exp_bit;

  // Mode 00 passes x, 11 inverts x, the two mixed modes select y.
  always_comb begin
    k_next = k + KW'(1);
    case (mode_r)
      2'b00:   exp_bit = x_r[k];
      2'b11:   exp_bit = ~x_r[k];
      default: exp_bit = y_r[k];
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      x_r      <= '0;
      y_r      <= '0;
      mode_r   <= '0;
      gate_x   <= 1'b0;
      gate_y   <= 1'b0;
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= RUN;
            k        <= '0;
            x_r      <= in_x;
            y_r      <= in_y;
            mode_r   <= in_mode;
            out_data <= '0;
            out_err  <= 1'b0;
            gate_x   <= in_x[0];
            gate_y   <= in_y[0];
            gate_a   <= in_mode[1];
            gate_b   <= in_mode[0];
          end
        end
        RUN: begin
          out_data[k] <= gate_f;
          if (gate_f != exp_bit)
            out_err <= 1'b1;
          // Last step parks the gate inputs at 0 while the result waits in DONE.
          if (k == K_LAST) begin
            state  <= DONE;
            gate_x <= 1'b0;
            gate_y <= 1'b0;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
          end else begin
            k      <= k_next;
            gate_x <= x_r[k_next];
            gate_y <= y_r[k_next];
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mf_serial_driver.sv
// Directed bench for mf_serial_driver: stimulus pushes expected results, a negedge monitor pops on each handshake.
module tb_mf_serial_driver;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_x = '0;
  logic [WIDTH-1:0] in_y = '0;
  logic [1:0]       in_mode = '0;
  logic             gate_x, gate_y, gate_a, gate_b;
  logic             gate_f;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             stuck = 1'b0;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Ideal multifunction gate, optionally stuck at 0.
  always_comb begin
    if (stuck)
      gate_f = 1'b0;
    else begin
      case ({gate_a, gate_b})
        2'b00:   gate_f = gate_x;
        2'b11:   gate_f = ~gate_x;
        default: gate_f = gate_y;
      endcase
    end
  end

  mf_serial_driver #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_mode  (in_mode),
    .gate_x   (gate_x),
    .gate_y   (gate_y),
    .gate_a   (gate_a),
    .gate_b   (gate_b),
    .gate_f   (gate_f),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_gates_zero(input string tag);
    check({tag, "_gates"}, {gate_x, gate_y, gate_a, gate_b}, 4'b0000);
  endtask

  // Monitor: every completed output handshake must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got out_valid=1 with data 0x%0h, expected no pending result", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", {24'b0, out_data}, {24'b0, e.data});
          check("out_err", {31'b0, out_err}, {31'b0, e.err});
        end
      end
    end
  end

  // Issue one command and follow it to completion; stall = DONE cycles with out_ready low.
  task automatic run_cmd(input logic [7:0] x, input logic [7:0] y, input logic [1:0] mode,
                         input logic [7:0] exp_d, input logic exp_e, input int stall);
    int i;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_mode  = mode;
    sb.push_back({exp_d, exp_e});
    @(posedge clk); #1;
    // Junk on the inputs while busy must be ignored.
    in_valid  = 1'b1;
    in_x      = ~x;
    in_y      = ~y;
    in_mode   = ~mode;
    out_ready = (stall == 0);
    i = 0;
    while (!out_valid && i < 20) begin
      if (i < WIDTH) begin
        check("gate_x", gate_x, x[i]);
        check("gate_y", gate_y, y[i]);
        check("gate_ab", {gate_a, gate_b}, mode);
        check("in_ready_busy", in_ready, 0);
      end
      @(posedge clk); #1;
      i++;
    end
    in_valid = 1'b0;
    check("valid_latency", i, WIDTH);
    check_gates_zero("done");
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, exp_d);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_fall", out_valid, 0);
    check("in_ready_back", in_ready, 1);
    check("data_retained", out_data, exp_d);
    check("err_retained", out_err, exp_e);
    check_gates_zero("idle");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with a command offered: nothing may be accepted.
    in_valid = 1'b1;
    in_x     = 8'hFF;
    in_mode  = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check_gates_zero("rst");
    @(posedge clk); #1;
    check("rst_idle_valid", out_valid, 0);

    run_cmd(8'hA5, 8'h00, 2'b00, 8'hA5, 1'b0, 0);
    run_cmd(8'h3C, 8'h00, 2'b11, 8'hC3, 1'b0, 0);
    run_cmd(8'hFF, 8'h96, 2'b01, 8'h96, 1'b0, 0);
    run_cmd(8'hFF, 8'h5A, 2'b10, 8'h5A, 1'b0, 0);
    stuck = 1'b1;
    run_cmd(8'h00, 8'h00, 2'b11, 8'h00, 1'b1, 0);
    stuck = 1'b0;
    run_cmd(8'h3E, 8'hC1, 2'b00, 8'h3E, 1'b0, 5);

    // Reset in the middle of RUN at step 3 discards the command.
    in_valid = 1'b1;
    in_x     = 8'hF7;
    in_y     = 8'h00;
    in_mode  = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("k3_gate_x", gate_x, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check_gates_zero("midrst");
    repeat (WIDTH + 2) begin
      @(posedge clk); #1;
      check("midrst_no_valid", out_valid, 0);
    end
    run_cmd(8'h0F, 8'h00, 2'b00, 8'h0F, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
